// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and constants for the PISO transmit arbiter.
package piso_pkg;
  localparam int DATA_W = 16;
  localparam int ID_W = 3;
  localparam logic [7:0] HDR_SYNC = 8'hA5;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, GAP, HDR_LOAD, HDR_WAIT} state_t;
endpackage

// File: rtl/piso_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set request at or above ptr.
module rr_pick
  import piso_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  grant,
  output logic             valid
);
  logic [7:0]      w_req8;
  logic [ID_W-1:0] w_idx;
  // Scan from the farthest candidate down so the nearest one to ptr wins.
  always_comb begin
    w_req8 = 8'(req);
    w_idx  = '0;
    grant  = '0;
    valid  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (w_req8[w_idx]) begin
        grant = w_idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: round-robin sharing of one PISO serializer between N_REQ word sources.
// Define PISO_ID_HEADER_EN to send an {A5, 5'b0, id} header word ahead of each data word.
module piso_tx_arbiter
  import piso_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       piso_in,
  output logic                    piso_valid,
  input  logic                    piso_done,
  output logic                    busy,
  output logic [ID_W-1:0]         cur_id,
  output logic                    err_timeout,
  input  logic                    err_clr
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            r_state;
  logic [N_REQ-1:0]  r_ack;
  logic [DATA_W-1:0] r_piso;
  logic              r_valid;
  logic [ID_W-1:0]   r_cur;
  logic              r_err;
  logic [ID_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
`ifdef PISO_ID_HEADER_EN
  logic [DATA_W-1:0] r_word;
`endif

  logic [ID_W-1:0]   w_grant;
  logic              w_gvalid;
  logic [DATA_W-1:0] w_words [8];
  logic [CNT_W-1:0]  w_cnt_nxt;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .valid (w_gvalid)
  );

  always_comb begin
    for (int i = 0; i < 8; i++) w_words[i] = '0;
    for (int i = 0; i < N_REQ; i++) w_words[i] = data[i*DATA_W +: DATA_W];
  end

  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ack   <= '0;
      r_piso  <= '0;
      r_valid <= 1'b0;
      r_cur   <= '0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
`ifdef PISO_ID_HEADER_EN
      r_word  <= '0;
`endif
    end else begin
      r_ack   <= '0;
      r_valid <= 1'b0;
      // A timeout in this same cycle overrides the clear below.
      if (err_clr) r_err <= 1'b0;
      case (r_state)
        IDLE:
          if (w_gvalid) begin
            r_ack <= N_REQ'(1) << w_grant;
            r_cur <= w_grant;
            r_ptr <= (int'(w_grant) == N_REQ - 1) ? '0 : w_grant + ID_W'(1);
`ifdef PISO_ID_HEADER_EN
            r_word  <= w_words[w_grant];
            r_piso  <= {HDR_SYNC, 5'b0, w_grant};
            r_state <= HDR_LOAD;
`else
            r_piso  <= w_words[w_grant];
            r_state <= LOAD;
`endif
          end
        LOAD, HDR_LOAD: begin
          r_valid <= 1'b1;
          r_cnt   <= '0;
          r_state <= (r_state == HDR_LOAD) ? HDR_WAIT : WAIT_DONE;
        end
        WAIT_DONE, HDR_WAIT:
          if (piso_done) begin
            r_cnt <= '0;
`ifdef PISO_ID_HEADER_EN
            if (r_state == HDR_WAIT) begin
              r_piso  <= r_word;
              r_state <= LOAD;
            end else
              r_state <= (GAP_CYCLES == 0) ? IDLE : GAP;
`else
            r_state <= (GAP_CYCLES == 0) ? IDLE : GAP;
`endif
          end else if (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else
            r_cnt <= w_cnt_nxt;
        GAP:
          if (w_cnt_nxt == CNT_W'(GAP_CYCLES)) r_state <= IDLE;
          else r_cnt <= w_cnt_nxt;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign piso_in     = r_piso;
  assign piso_valid  = r_valid;
  assign busy        = (r_state != IDLE);
  assign cur_id      = r_cur;
  assign err_timeout = r_err;
endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb_piso_tx_arbiter: directed and randomized checks of grant order, timing, timeout and reset.
module tb_piso_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int GAP = 2;
  localparam int TO  = 63;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] data;
  logic [N-1:0] ack;
  logic [W-1:0] piso_in;
  logic         piso_valid;
  logic         piso_done;
  logic         busy;
  logic [2:0]   cur_id;
  logic         err_timeout;
  logic         err_clr;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int ptr_m   = 0;
  logic [W-1:0] words [N];

  always #5 clk = ~clk;

  always_comb for (int i = 0; i < N; i++) data[i*W +: W] = words[i];

  piso_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .piso_in     (piso_in),
    .piso_valid  (piso_valid),
    .piso_done   (piso_done),
    .busy        (busy),
    .cur_id      (cur_id),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = r >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One complete word from grant to return to idle, with done after lat extra cycles.
  task automatic word(input int lat);
    int g;
    logic [W-1:0] d;
    g = pick(req, ptr_m);
    step();
    chk("ack_grant", 32'(ack), 32'(1) << g);
    chk("cur_id", 32'(cur_id), 32'(g));
    chk("busy_grant", 32'(busy), 1);
    d = words[g];
    ptr_m = (g + 1) % N;
    words[g] = W'($urandom);
`ifdef PISO_ID_HEADER_EN
    step();
    chk("hdr_valid", 32'(piso_valid), 1);
    chk("hdr_word", 32'(piso_in), 32'hA500 + 32'(g));
    repeat (lat) step();
    piso_done = 1'b1;
    step();
    piso_done = 1'b0;
    chk("hdr_to_data", 32'(piso_in), 32'(d));
`endif
    step();
    chk("load_valid", 32'(piso_valid), 1);
    chk("load_word", 32'(piso_in), 32'(d));
    step();
    chk("valid_pulse", 32'(piso_valid), 0);
    chk("ack_pulse", 32'(ack), 0);
    repeat (lat) step();
    chk("word_held", 32'(piso_in), 32'(d));
    piso_done = 1'b1;
    step();
    piso_done = 1'b0;
    chk("busy_gap", 32'(busy), 1);
    step();
    chk("busy_gap2", 32'(busy), 1);
    step();
    chk("busy_fall", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    piso_done = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < N; i++) words[i] = '0;
    step();
    step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_piso_in", 32'(piso_in), 0);
    chk("rst_valid", 32'(piso_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cur_id", 32'(cur_id), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b0;
    step();

    words[0] = 16'hBEEF;
    req = 4'b0001;
    word(17);
    req = 4'b0000;
    step();
    chk("idle_no_req", 32'(busy), 0);

    req = 4'b1111;
    for (int i = 0; i < 5; i++) word(3 + i);
    req = 4'b0000;

    step();
    req = 4'b0100;
    word(2);
    req = 4'b0011;
    word(1);
    word(0);
    req = 4'b0000;

    for (int i = 0; i < 6; i++) begin
      req = N'($urandom_range(1, 15));
      for (int j = 0; j < N; j++) words[j] = W'($urandom);
      word(int'($urandom_range(0, 20)));
    end
    req = 4'b0000;
    step();

    req = 4'b0001;
    step();
    chk("to_ack", 32'(ack), 1);
    ptr_m = 1;
    req = 4'b0000;
    step();
    chk("to_valid", 32'(piso_valid), 1);
    repeat (TO - 1) step();
    chk("to_err_early", 32'(err_timeout), 0);
    chk("to_busy_early", 32'(busy), 1);
    step();
    chk("to_err_set", 32'(err_timeout), 1);
    chk("to_idle", 32'(busy), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(err_timeout), 0);

    req = 4'b0001;
    step();
    req = 4'b0000;
    ptr_m = 1;
    step();
    repeat (TO - 1) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_set_wins", 32'(err_timeout), 1);

    req = 4'b1111;
    step();
    chk("mid_ack", 32'(ack), 32'(1) << pick(4'b1111, ptr_m));
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_piso_in", 32'(piso_in), 0);
    chk("arst_valid", 32'(piso_valid), 0);
    chk("arst_ack", 32'(ack), 0);
    chk("arst_cur_id", 32'(cur_id), 0);
    chk("arst_err", 32'(err_timeout), 0);
    step();
    rst = 1'b0;
    ptr_m = 0;
    word(4);
    req = 4'b0000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
